gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Register-mapped controller that configures and sequences the 8-bit GPIO port datapath for the VeSPA SoC.
- Owns the direction and output-data registers that drive the port.
- Synchronises the port's read-back value and detects per-pin edges.
- Raises a maskable, sticky interrupt.
- Sits between the peripheral bus slave interface and the combinational GPIO port.

Parameters:
- WIDTH, 8, number of GPIO bits managed (register width).
- SYNC_STAGES, 2, flip-flop stages on port read-back (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- bus_req  input  1  bus access request; held high until bus_ack.
- bus_we  input  1  1 = write, 0 = read; valid while bus_req high.
- bus_addr  input  3  register select.
- bus_wdata  input  WIDTH  write data.
- bus_rdata  output  WIDTH  read data; valid only while bus_ack = 1, else 0.
- bus_ack  output  1  one-cycle completion pulse.
- direction  output  WIDTH  to port: 1 = pin driven (output), 0 = input.
- write_reg  output  WIDTH  to port: output data.
- read_reg  input  WIDTH  from port: raw pin read-back (asynchronous to clk).
- irq  output  1  registered interrupt, active-high level.

Behaviour:
- Reset (rst_n = 0 at a rising edge) clears all state:
  - direction = 0, write_reg = 0, IE = 0, FLAG = 0, EDGE = all ones (rising).
  - Sync chain and previous-sample register = 0.
  - irq = 0, bus_ack = 0, bus_rdata = 0, FSM to IDLE.
  - Reset mid-transaction aborts it; no ack is issued for that request.
- Register map (bus_addr):
  - 0 DIR: R/W.
  - 1 OUT: R/W.
  - 2 IN: RO, synchronised read_reg; writes ignored.
  - 3 IE: R/W interrupt enable per pin.
  - 4 FLAG: R, write-1-to-clear.
  - 5 EDGE: R/W, 1 = rising edge, 0 = falling edge.
  - 6-7: read 0, writes ignored; still acknowledged.
- Bus FSM has two states:
  - IDLE: when bus_req = 1, perform the write (register updates at this edge) or capture read data, then go to ACK.
  - ACK: bus_ack = 1 and bus_rdata valid for exactly one cycle, then return to IDLE.
  - Latency: ack appears one cycle after req is sampled. Back-to-back accesses take 2 cycles each.
  - Requester drops bus_req in the ack cycle. If req is still high in IDLE, it is a new access.
- Input path:
  - read_reg passes through SYNC_STAGES flops to give sync. A prev register holds sync delayed by one cycle.
  - rise = sync & ~prev. fall = ~sync & prev.
  - hit[i] = (EDGE[i] ? rise[i] : fall[i]) & ~direction[i]. Driven pins never set flags.
- FLAG update each cycle: FLAG <= (FLAG & ~clr) | hit.
  - clr = bus_wdata when a write to addr 4 occurs, else 0.
  - Set has priority over clear on the same bit in the same cycle.
- Latency from a pin change that is stable before clk edge N (SYNC_STAGES = 2):
  - sync updates at N+1.
  - FLAG sets at N+2.
  - irq rises at N+3 (irq <= |(FLAG & IE), registered).
- Changing IE or DIR does not alter FLAG. Setting IE on an already-pending flag raises irq the cycle after the IE write.
- Changing EDGE does not by itself create a hit (edge detection compares sync against prev only).
- Glitches shorter than one clk may be missed; no pulse stretching.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with bus_req = 1 -> all outputs 0, EDGE reads 0xFF, no bus_ack until one cycle after rst_n = 1.
- Register R/W: write DIR = 0x0F, then read back -> direction = 0x0F one cycle after the req sample, bus_ack pulses once, bus_rdata = 0x0F only in the ack cycle; read of addr 7 returns 0 with ack.
- Output drive: DIR = 0xFF, OUT = 0xA5 -> write_reg = 0xA5; writing 0x3C to IN leaves IN unchanged.
- Rising-edge irq: DIR = 0, IE = 0x10, read_reg[4] goes 0 -> 1 before edge N -> FLAG = 0x10 at N+2, irq = 1 at N+3; W1C write 0x10 to FLAG -> irq = 0 two cycles later.
- Falling edge and masking: EDGE = 0xFE, bit 0 falls -> FLAG bit 0 set. With DIR bit 0 = 1, the same toggle sets no flag. With IE = 0, a flag sets but irq stays 0.
- Simultaneous set and clear: a W1C of bit 2 lands in the same cycle a new bit-2 hit occurs -> FLAG bit 2 remains 1 and irq remains asserted.

Source files
------------

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: direction/output registers, synchronised read-back, edge flags, maskable irq.
// Bus access acks one cycle after req is sampled (2 cycles per access); pin edge -> FLAG in 2 cycles, irq in 3.
module gpio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic             bus_ack,
  output logic [WIDTH-1:0] direction,
  output logic [WIDTH-1:0] write_reg,
  input  logic [WIDTH-1:0] read_reg,
  output logic             irq
);

  localparam logic [2:0] ADDR_DIR  = 3'd0;
  localparam logic [2:0] ADDR_OUT  = 3'd1;
  localparam logic [2:0] ADDR_IN   = 3'd2;
  localparam logic [2:0] ADDR_IE   = 3'd3;
  localparam logic [2:0] ADDR_FLAG = 3'd4;
  localparam logic [2:0] ADDR_EDGE = 3'd5;

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] ie_q;
  logic [WIDTH-1:0] flag_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rdata_mux;
  logic             acc_vld;

  assign sync_w  = sync_q[SYNC_STAGES-1];
  assign rise    = sync_w & ~prev_q;
  assign fall    = ~sync_w & prev_q;
  // Driven pins never raise flags, whatever the edge selection says.
  assign hit     = ((edge_q & rise) | (~edge_q & fall)) & ~direction;
  assign acc_vld = (state == IDLE) && bus_req;
  assign clr     = (acc_vld && bus_we && bus_addr == ADDR_FLAG) ? bus_wdata : '0;

  always_comb begin
    rdata_mux = '0;
    case (bus_addr)
      ADDR_DIR:  rdata_mux = direction;
      ADDR_OUT:  rdata_mux = write_reg;
      ADDR_IN:   rdata_mux = sync_w;
      ADDR_IE:   rdata_mux = ie_q;
      ADDR_FLAG: rdata_mux = flag_q;
      ADDR_EDGE: rdata_mux = edge_q;
      default:   rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      direction <= '0;
      write_reg <= '0;
      ie_q      <= '0;
      flag_q    <= '0;
      edge_q    <= '1;
      prev_q    <= '0;
      irq       <= 1'b0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= read_reg;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_w;
      // A new hit wins over a simultaneous write-1-to-clear of the same bit.
      flag_q <= (flag_q & ~clr) | hit;
      irq    <= |(flag_q & ie_q);

      if (state == IDLE) begin
        bus_ack   <= 1'b0;
        bus_rdata <= '0;
        if (bus_req) begin
          if (bus_we) begin
            case (bus_addr)
              ADDR_DIR:  direction <= bus_wdata;
              ADDR_OUT:  write_reg <= bus_wdata;
              ADDR_IE:   ie_q      <= bus_wdata;
              ADDR_EDGE: edge_q    <= bus_wdata;
              default:   ;
            endcase
          end
          bus_rdata <= bus_we ? '0 : rdata_mux;
          bus_ack   <= 1'b1;
          state     <= ACK;
        end
      end else begin
        bus_ack   <= 1'b0;
        bus_rdata <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: inputs change and outputs are sampled on the falling clock edge.
module tb_gpio_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bus_req;
  logic             bus_we;
  logic [2:0]       bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic [WIDTH-1:0] bus_rdata;
  logic             bus_ack;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] write_reg;
  logic [WIDTH-1:0] read_reg;
  logic             irq;

  int n_assert = 0;
  int n_fail   = 0;

  gpio_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .direction (direction),
    .write_reg (write_reg),
    .read_reg  (read_reg),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One bus access from a falling edge; returns at the falling edge after the ack cycle.
  task automatic bus_xfer(input logic we, input logic [2:0] a, input logic [WIDTH-1:0] d,
                          output logic [WIDTH-1:0] rd);
    int n;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_ack !== 1'b1 && n < 4);
    check("ack_seen", bus_ack, 1'b1);
    check("ack_latency", n, 1);
    rd = bus_rdata;
    bus_req = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    @(negedge clk);
    check("ack_single", bus_ack, 1'b0);
    check("rdata_idle", bus_rdata, 8'h00);
  endtask

  task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] v;
    bus_xfer(1'b0, a, '0, v);
    check(tag, v, exp);
  endtask

  initial begin
    rst_n = 1'b0; bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd0;
    bus_wdata = '0; read_reg = '0;

    // Reset held for 3 cycles with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ack", bus_ack, 1'b0);
      check("rst_outputs", {irq, direction, write_reg, bus_rdata}, 25'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack", bus_ack, 1'b1);
    check("post_rst_rdata", bus_rdata, 8'h00);
    bus_req = 1'b0;
    @(negedge clk);
    check("post_rst_ack_drop", bus_ack, 1'b0);
    rd_chk("edge_reset", 3'd5, 8'hFF);
    rd_chk("flag_reset", 3'd4, 8'h00);

    // Register read/write
    wr(3'd0, 8'h0F);
    check("dir_out", direction, 8'h0F);
    rd_chk("dir_rd", 3'd0, 8'h0F);
    rd_chk("addr7_rd", 3'd7, 8'h00);
    wr(3'd7, 8'hFF);
    rd_chk("addr7_after_wr", 3'd7, 8'h00);

    // Output drive and read-only IN
    wr(3'd0, 8'hFF);
    wr(3'd1, 8'hA5);
    check("write_reg", write_reg, 8'hA5);
    read_reg = 8'h5A;
    wait_cyc(4);
    rd_chk("in_rd", 3'd2, 8'h5A);
    wr(3'd2, 8'h3C);
    rd_chk("in_ro", 3'd2, 8'h5A);
    read_reg = 8'h00;
    wait_cyc(4);
    rd_chk("flag_driven", 3'd4, 8'h00);
    rd_chk("out_rd", 3'd1, 8'hA5);

    // Rising-edge interrupt on bit 4
    wr(3'd0, 8'h00);
    wr(3'd3, 8'h10);
    rd_chk("ie_rd", 3'd3, 8'h10);
    read_reg = 8'h10;
    wait_cyc(1);
    check("irq_n0", irq, 1'b0);
    wait_cyc(1);
    check("irq_n1", irq, 1'b0);
    wait_cyc(1);
    check("irq_n2", irq, 1'b0);
    wait_cyc(1);
    check("irq_n3", irq, 1'b1);
    rd_chk("flag_rise", 3'd4, 8'h10);
    wr(3'd4, 8'h10);
    check("irq_w1c", irq, 1'b0);
    rd_chk("flag_cleared", 3'd4, 8'h00);

    // Falling edge select on bit 0
    wr(3'd5, 8'hFE);
    read_reg = 8'h11;
    wait_cyc(4);
    rd_chk("flag_rise_ignored", 3'd4, 8'h00);
    read_reg = 8'h10;
    wait_cyc(4);
    rd_chk("flag_fall", 3'd4, 8'h01);
    check("irq_masked_b0", irq, 1'b0);
    wr(3'd4, 8'h01);

    // Driven pin never flags
    wr(3'd0, 8'h01);
    read_reg = 8'h11;
    wait_cyc(4);
    read_reg = 8'h10;
    wait_cyc(4);
    rd_chk("flag_dir_mask", 3'd4, 8'h00);
    wr(3'd0, 8'h00);

    // IE = 0: flag sets, irq stays low; enabling IE raises irq next cycle
    wr(3'd3, 8'h00);
    read_reg = 8'h00;
    wait_cyc(4);
    read_reg = 8'h10;
    wait_cyc(4);
    check("irq_ie0", irq, 1'b0);
    rd_chk("flag_ie0", 3'd4, 8'h10);
    wr(3'd3, 8'h10);
    check("irq_ie_set", irq, 1'b1);
    wr(3'd4, 8'h10);
    check("irq_clr2", irq, 1'b0);

    // Simultaneous set and clear on bit 2
    wr(3'd3, 8'h04);
    read_reg = 8'h14;
    wait_cyc(4);
    check("irq_b2", irq, 1'b1);
    read_reg = 8'h10;
    wait_cyc(4);
    read_reg = 8'h14;
    wait_cyc(2);
    wr(3'd4, 8'h04);
    check("irq_set_wins", irq, 1'b1);
    rd_chk("flag_set_wins", 3'd4, 8'h04);
    wr(3'd4, 8'h04);
    check("irq_final_clr", irq, 1'b0);
    rd_chk("flag_final", 3'd4, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
